// File: rtl/sindoku_pkg.sv
// Shared types and constants for the 4x4 SINdoku game core.
// Holds the state encoding, default puzzle and group-to-cell table.
package sindoku_pkg;

  localparam int CW      = 3;
  localparam int NUM_GRP = 12;

  localparam logic [63:0] DEF_PUZZLE =
    64'h1004_0400_0040_4001;

  typedef enum logic [4:0] {
    S_I         = 5'b00001,
    S_SOLVE     = 5'b00010,
    S_CHECK     = 5'b00100,
    S_CORRECT   = 5'b01000,
    S_INCORRECT = 5'b10000
  } state_t;

  typedef logic [CW-1:0] cell_t;

  // rows, then cols, then 2x2 boxes in row-major box order
  localparam logic [3:0] GRP_TBL [NUM_GRP][4] = '{
    '{4'd0,  4'd1,  4'd2,  4'd3},
    '{4'd4,  4'd5,  4'd6,  4'd7},
    '{4'd8,  4'd9,  4'd10, 4'd11},
    '{4'd12, 4'd13, 4'd14, 4'd15},
    '{4'd0,  4'd4,  4'd8,  4'd12},
    '{4'd1,  4'd5,  4'd9,  4'd13},
    '{4'd2,  4'd6,  4'd10, 4'd14},
    '{4'd3,  4'd7,  4'd11, 4'd15},
    '{4'd0,  4'd1,  4'd4,  4'd5},
    '{4'd2,  4'd3,  4'd6,  4'd7},
    '{4'd8,  4'd9,  4'd12, 4'd13},
    '{4'd10, 4'd11, 4'd14, 4'd15}
  };

endpackage

// File: rtl/sindoku_group_check.sv
// Combinational pass test for one group of four cells.
// Passes only when the values 1..4 each appear exactly once.
module sindoku_group_check
  import sindoku_pkg::*;
(
  input  logic [2:0] c0,
  input  logic [2:0] c1,
  input  logic [2:0] c2,
  input  logic [2:0] c3,
  output logic       pass
);

  function automatic logic [3:0] onehot(
    input cell_t v
  );
    case (v)
      3'd1:    onehot = 4'b0001;
      3'd2:    onehot = 4'b0010;
      3'd3:    onehot = 4'b0100;
      3'd4:    onehot = 4'b1000;
      default: onehot = 4'b0000;
    endcase
  endfunction

  assign pass = (onehot(c0) | onehot(c1) |
                 onehot(c2) | onehot(c3))
                == 4'b1111;

endmodule

// File: rtl/sindoku_board_ctrl.sv
// SINdoku board controller: cursor, guarded entry and
// a sequential 12-group solution check with one-hot status.
module sindoku_board_ctrl
  import sindoku_pkg::*;
#(
  parameter logic [63:0] PUZZLE = DEF_PUZZLE,
  parameter int          N_GRP  = NUM_GRP
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       R,
  input  logic       L,
  input  logic       U,
  input  logic       D,
  input  logic       C,
  input  logic       CheckSolu,
  input  logic [3:0] userIn,
  output logic       q_I,
  output logic       q_Solve,
  output logic       q_Check,
  output logic       q_Correct,
  output logic       q_Incorrect,
  output logic [1:0] cur_row,
  output logic [1:0] cur_col,
  output logic [3:0] cur_val,
  output logic       cur_given,
  output logic       wr_reject
);

  state_t      state;
  state_t      state_nx;
  cell_t       board [16];
  logic [15:0] given;
  logic [3:0]  gcnt;
  logic        fail;
  logic [3:0]  cidx;
  logic        do_wr;
  logic        rej_nx;
  logic        chk_start;
  logic        chk_step;
  logic        grp_pass;
  logic        last_grp;
  logic [1:0]  row_nx;
  logic [1:0]  col_nx;
  cell_t       gv [4];

  assign cidx     = {cur_row, cur_col};
  assign last_grp = gcnt == 4'(N_GRP - 1);

  always_comb begin
    state_nx  = state;
    do_wr     = 1'b0;
    rej_nx    = 1'b0;
    chk_start = 1'b0;
    chk_step  = 1'b0;
    row_nx    = cur_row;
    col_nx    = cur_col;
    unique case (state)
      S_I: state_nx = S_SOLVE;
      S_SOLVE: begin
        if (C) begin
          if (given[cidx] || userIn > 4'd4)
            rej_nx = 1'b1;
          else
            do_wr = 1'b1;
        end else begin
          if (R)      col_nx = cur_col + 2'd1;
          else if (L) col_nx = cur_col - 2'd1;
          else if (U) row_nx = cur_row - 2'd1;
          else if (D) row_nx = cur_row + 2'd1;
          if (CheckSolu) begin
            state_nx  = S_CHECK;
            chk_start = 1'b1;
          end
        end
      end
      S_CHECK: begin
        if (!CheckSolu) begin
          state_nx = S_SOLVE;
        end else begin
          chk_step = 1'b1;
          if (last_grp)
            state_nx = (fail || !grp_pass)
                     ? S_INCORRECT : S_CORRECT;
        end
      end
      S_CORRECT, S_INCORRECT: begin
        if (!CheckSolu) state_nx = S_SOLVE;
      end
      default: state_nx = S_I;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= S_I;
      given     <= '0;
      cur_row   <= '0;
      cur_col   <= '0;
      wr_reject <= 1'b0;
      gcnt      <= '0;
      fail      <= 1'b0;
      for (int k = 0; k < 16; k++)
        board[k] <= '0;
    end else begin
      state     <= state_nx;
      cur_row   <= row_nx;
      cur_col   <= col_nx;
      wr_reject <= rej_nx;
      if (state == S_I) begin
        for (int k = 0; k < 16; k++) begin
          board[k] <= PUZZLE[4*k +: CW];
          given[k] <= PUZZLE[4*k +: 4] != 4'd0;
        end
      end
      if (do_wr)
        board[cidx] <= userIn[CW-1:0];
      if (chk_start) begin
        gcnt <= '0;
        fail <= 1'b0;
      end else if (chk_step) begin
        gcnt <= gcnt + 4'd1;
        if (!grp_pass) fail <= 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++)
      gv[i] = board[GRP_TBL[gcnt][i]];
  end

  sindoku_group_check u_grp (
    .c0   (gv[0]),
    .c1   (gv[1]),
    .c2   (gv[2]),
    .c3   (gv[3]),
    .pass (grp_pass)
  );

  assign q_I         = state[0];
  assign q_Solve     = state[1];
  assign q_Check     = state[2];
  assign q_Correct   = state[3];
  assign q_Incorrect = state[4];

  assign cur_val   = {1'b0, board[cidx]};
  assign cur_given = given[cidx];

endmodule

// File: tb/tb_sindoku_board_ctrl.sv
// Self-checking bench for sindoku_board_ctrl against a
// set-based board model of the game rules.
module tb_sindoku_board_ctrl;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b1;
  logic       R = 1'b0, L = 1'b0, U = 1'b0, D = 1'b0;
  logic       C = 1'b0, CheckSolu = 1'b0;
  logic [3:0] userIn = 4'd0;
  logic       q_I, q_Solve, q_Check, q_Correct, q_Incorrect;
  logic [1:0] cur_row, cur_col;
  logic [3:0] cur_val;
  logic       cur_given, wr_reject;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [63:0] PZ = 64'h1004_0400_0040_4001;

  int mb [16];
  bit mg [16];
  int mrow, mcol;
  bit mrej;

  sindoku_board_ctrl dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .R(R), .L(L), .U(U), .D(D), .C(C),
    .CheckSolu(CheckSolu), .userIn(userIn),
    .q_I(q_I), .q_Solve(q_Solve), .q_Check(q_Check),
    .q_Correct(q_Correct), .q_Incorrect(q_Incorrect),
    .cur_row(cur_row), .cur_col(cur_col),
    .cur_val(cur_val), .cur_given(cur_given),
    .wr_reject(wr_reject)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic model_load();
    logic [63:0] p;
    p = PZ;
    for (int k = 0; k < 16; k++) begin
      mb[k] = int'((p >> (4 * k)) & 64'hF);
      mg[k] = (mb[k] != 0);
    end
    mrow = 0;
    mcol = 0;
    mrej = 0;
  endtask

  function automatic int gcell(int g, int i);
    int b;
    if (g < 4) return g * 4 + i;
    if (g < 8) return i * 4 + (g - 4);
    b = g - 8;
    return (b / 2) * 8 + (b % 2) * 2 + (i / 2) * 4 + (i % 2);
  endfunction

  function automatic bit model_solved();
    int seen, v;
    for (int g = 0; g < 12; g++) begin
      seen = 0;
      for (int i = 0; i < 4; i++) begin
        v = mb[gcell(g, i)];
        if (v < 1 || v > 4) return 1'b0;
        seen = seen | (1 << (v - 1));
      end
      if (seen != 15) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic act(input bit r, l, u, d, c, input int v);
    int k;
    R = r; L = l; U = u; D = d; C = c;
    userIn = v[3:0];
    step();
    R = 0; L = 0; U = 0; D = 0; C = 0;
    mrej = 0;
    if (c) begin
      k = mrow * 4 + mcol;
      if (mg[k] || v > 4) mrej = 1;
      else mb[k] = v;
    end else if (r) mcol = (mcol + 1) % 4;
    else if (l) mcol = (mcol + 3) % 4;
    else if (u) mrow = (mrow + 3) % 4;
    else if (d) mrow = (mrow + 1) % 4;
  endtask

  task automatic goto(input int tr, input int tc);
    for (int n = 0; n < 4 && mcol != tc; n++)
      act(1, 0, 0, 0, 0, 0);
    for (int n = 0; n < 4 && mrow != tr; n++)
      act(0, 0, 0, 1, 0, 0);
  endtask

  task automatic put(input int k, input int v);
    goto(k / 4, k % 4);
    act(0, 0, 0, 0, 1, v);
  endtask

  task automatic run_check(output int ncyc);
    CheckSolu = 1;
    step();
    ncyc = 0;
    while (q_Check && ncyc < 30) begin
      ncyc++;
      step();
    end
  endtask

  task automatic test_reset();
    #2 Reset_n = 0;
    #3;
    n_cmp++; if (q_I !== 1'b1) begin n_bad++;
      $display("FAIL rst_qI: got %b want 1", q_I); end
    n_cmp++; if (q_Solve !== 1'b0) begin n_bad++;
      $display("FAIL rst_qSolve: got %b want 0", q_Solve); end
    n_cmp++; if ({cur_row, cur_col} !== 4'd0) begin n_bad++;
      $display("FAIL rst_cursor: got %0d,%0d want 0,0", cur_row, cur_col); end
    n_cmp++; if (cur_val !== 4'd0) begin n_bad++;
      $display("FAIL rst_val: got %0d want 0", cur_val); end
    n_cmp++; if (cur_given !== 1'b0 || wr_reject !== 1'b0) begin n_bad++;
      $display("FAIL rst_flags: got %b%b want 00", cur_given, wr_reject); end
    @(negedge Clk) Reset_n = 1;
    #1;
    n_cmp++; if (q_I !== 1'b1) begin n_bad++;
      $display("FAIL init_qI: got %b want 1", q_I); end
    step();
    model_load();
    n_cmp++; if (q_Solve !== 1'b1 || q_I !== 1'b0) begin n_bad++;
      $display("FAIL load_state: got I=%b S=%b want I=0 S=1", q_I, q_Solve); end
    n_cmp++; if (cur_val !== 4'd1 || cur_given !== 1'b1) begin n_bad++;
      $display("FAIL load_cell0: got v=%0d g=%b want v=1 g=1", cur_val, cur_given); end
  endtask

  task automatic test_cursor_wrap();
    act(0, 1, 0, 0, 0, 0);
    n_cmp++; if (cur_row !== 2'd0 || cur_col !== 2'd3 || cur_val !== 4'd4) begin n_bad++;
      $display("FAIL wrap_L: got %0d,%0d v=%0d want 0,3 v=4", cur_row, cur_col, cur_val); end
    act(0, 0, 1, 0, 0, 0);
    n_cmp++; if (cur_row !== 2'd3 || cur_col !== 2'd3 || cur_val !== 4'd1) begin n_bad++;
      $display("FAIL wrap_U: got %0d,%0d v=%0d want 3,3 v=1", cur_row, cur_col, cur_val); end
    act(1, 0, 0, 1, 0, 0);
    n_cmp++; if (cur_row !== 2'd3 || cur_col !== 2'd0 || cur_val !== 4'd4) begin n_bad++;
      $display("FAIL prio_RD: got %0d,%0d v=%0d want 3,0 v=4", cur_row, cur_col, cur_val); end
  endtask

  task automatic test_write_rules();
    goto(0, 1);
    act(0, 0, 0, 0, 1, 2);
    n_cmp++; if (cur_val !== 4'd2 || wr_reject !== 1'b0) begin n_bad++;
      $display("FAIL wr_ok: got v=%0d rej=%b want v=2 rej=0", cur_val, wr_reject); end
    goto(0, 0);
    act(0, 0, 0, 0, 1, 3);
    n_cmp++; if (cur_val !== 4'd1 || wr_reject !== 1'b1) begin n_bad++;
      $display("FAIL wr_given: got v=%0d rej=%b want v=1 rej=1", cur_val, wr_reject); end
    act(0, 0, 0, 0, 0, 0);
    n_cmp++; if (wr_reject !== 1'b0) begin n_bad++;
      $display("FAIL rej_pulse: got %b want 0", wr_reject); end
    goto(0, 2);
    act(0, 0, 0, 0, 1, 7);
    n_cmp++; if (cur_val !== 4'd0 || wr_reject !== 1'b1) begin n_bad++;
      $display("FAIL wr_illegal: got v=%0d rej=%b want v=0 rej=1", cur_val, wr_reject); end
  endtask

  task automatic test_empty_incorrect();
    int n;
    run_check(n);
    n_cmp++; if (n !== 12 || q_Incorrect !== 1'b1) begin n_bad++;
      $display("FAIL empty_chk: got cyc=%0d inc=%b want cyc=12 inc=1", n, q_Incorrect); end
    CheckSolu = 0;
    step();
    n_cmp++; if (q_Solve !== 1'b1) begin n_bad++;
      $display("FAIL empty_back: got %b want 1", q_Solve); end
  endtask

  task automatic test_correct();
    int n;
    int ks [10] = '{1, 2, 4, 6, 7, 8, 9, 11, 13, 14};
    int vs [10] = '{2, 3, 3, 1, 2, 2, 1, 3, 3, 2};
    for (int i = 0; i < 10; i++) put(ks[i], vs[i]);
    run_check(n);
    n_cmp++; if (n !== 12) begin n_bad++;
      $display("FAIL ok_cycles: got %0d want 12", n); end
    n_cmp++; if (q_Correct !== model_solved() || q_Correct !== 1'b1) begin n_bad++;
      $display("FAIL ok_result: got %b want %b", q_Correct, model_solved()); end
    act(1, 0, 0, 0, 0, 0);
    mcol = (mcol + 3) % 4;
    repeat (3) step();
    n_cmp++; if (q_Correct !== 1'b1 || cur_col !== mcol[1:0]) begin n_bad++;
      $display("FAIL ok_hold: got c=%b col=%0d want c=1 col=%0d", q_Correct, cur_col, mcol); end
    CheckSolu = 0;
    step();
    n_cmp++; if (q_Solve !== 1'b1 || cur_val !== mb[mrow*4+mcol][3:0]) begin n_bad++;
      $display("FAIL ok_back: got s=%b v=%0d want s=1 v=%0d", q_Solve, cur_val, mb[mrow*4+mcol]); end
  endtask

  task automatic test_incorrect();
    int n;
    put(14, 3);
    run_check(n);
    n_cmp++; if (n !== 12 || q_Incorrect !== !model_solved()) begin n_bad++;
      $display("FAIL bad_result: got cyc=%0d inc=%b want cyc=12 inc=%b", n, q_Incorrect, !model_solved()); end
    CheckSolu = 0;
    step();
    put(14, 2);
  endtask

  task automatic test_check_with_write();
    goto(1, 0);
    CheckSolu = 1;
    act(0, 0, 0, 0, 1, 3);
    n_cmp++; if (q_Solve !== 1'b1 || cur_val !== 4'd3) begin n_bad++;
      $display("FAIL cw_first: got s=%b v=%0d want s=1 v=3", q_Solve, cur_val); end
    step();
    n_cmp++; if (q_Check !== 1'b1) begin n_bad++;
      $display("FAIL cw_enter: got %b want 1", q_Check); end
    CheckSolu = 0;
    step();
  endtask

  task automatic test_abort();
    CheckSolu = 1;
    step();
    R = 1;
    repeat (4) step();
    R = 0;
    CheckSolu = 0;
    step();
    n_cmp++; if (q_Solve !== 1'b1 || q_Check !== 1'b0 || q_Correct !== 1'b0) begin n_bad++;
      $display("FAIL abort_state: got s=%b c=%b ok=%b want 1 0 0", q_Solve, q_Check, q_Correct); end
    n_cmp++; if (cur_row !== mrow[1:0] || cur_col !== mcol[1:0]) begin n_bad++;
      $display("FAIL abort_cursor: got %0d,%0d want %0d,%0d", cur_row, cur_col, mrow, mcol); end
    for (int k = 0; k < 16; k++) begin
      goto(k / 4, k % 4);
      n_cmp++; if (cur_val !== mb[k][3:0] || cur_given !== mg[k]) begin n_bad++;
        $display("FAIL abort_cell%0d: got v=%0d g=%b want v=%0d g=%b", k, cur_val, cur_given, mb[k], mg[k]); end
    end
  endtask

  task automatic test_random();
    int n;
    bit r, l, u, d, c;
    for (int it = 0; it < 300; it++) begin
      r = ($urandom_range(0, 2) == 0);
      l = ($urandom_range(0, 2) == 0);
      u = ($urandom_range(0, 2) == 0);
      d = ($urandom_range(0, 2) == 0);
      c = ($urandom_range(0, 3) == 0);
      act(r, l, u, d, c, int'($urandom_range(0, 7)));
      n_cmp++; if (cur_row !== mrow[1:0] || cur_col !== mcol[1:0]) begin n_bad++;
        $display("FAIL rnd_cursor it%0d: got %0d,%0d want %0d,%0d", it, cur_row, cur_col, mrow, mcol); end
      n_cmp++; if (cur_val !== mb[mrow*4+mcol][3:0] || cur_given !== mg[mrow*4+mcol]) begin n_bad++;
        $display("FAIL rnd_cell it%0d: got v=%0d g=%b want v=%0d g=%b", it, cur_val, cur_given, mb[mrow*4+mcol], mg[mrow*4+mcol]); end
      n_cmp++; if (wr_reject !== mrej) begin n_bad++;
        $display("FAIL rnd_rej it%0d: got %b want %b", it, wr_reject, mrej); end
      if (it % 100 == 99) begin
        run_check(n);
        n_cmp++; if (n !== 12 || q_Correct !== model_solved() || q_Incorrect !== !model_solved()) begin n_bad++;
          $display("FAIL rnd_check it%0d: got cyc=%0d ok=%b inc=%b want cyc=12 ok=%b", it, n, q_Correct, q_Incorrect, model_solved()); end
        CheckSolu = 0;
        step();
      end
    end
  endtask

  task automatic test_reset_mid_check();
    CheckSolu = 1;
    repeat (3) step();
    #2 Reset_n = 0;
    #1;
    n_cmp++; if (q_I !== 1'b1 || q_Check !== 1'b0) begin n_bad++;
      $display("FAIL mid_rst_state: got I=%b C=%b want 1 0", q_I, q_Check); end
    n_cmp++; if (cur_val !== 4'd0 || {cur_row, cur_col} !== 4'd0) begin n_bad++;
      $display("FAIL mid_rst_board: got v=%0d pos=%0d want 0 0", cur_val, {cur_row, cur_col}); end
    CheckSolu = 0;
    @(negedge Clk) Reset_n = 1;
    step();
    model_load();
    n_cmp++; if (q_Solve !== 1'b1 || cur_val !== 4'd1) begin n_bad++;
      $display("FAIL mid_rst_reload: got s=%b v=%0d want 1 1", q_Solve, cur_val); end
  endtask

  initial begin
    test_reset();
    test_cursor_wrap();
    test_write_rules();
    test_empty_incorrect();
    test_correct();
    test_incorrect();
    test_check_with_write();
    test_abort();
    test_random();
    test_reset_mid_check();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
